// File: rtl/hazard_pkg.sv
// Shared types, constants and helpers for the pipeline hazard/forwarding controller.
// Pure definitions, no logic or state.
package hazard_pkg;

  localparam int TW = 2;
  localparam int RW = 5;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [1:0] FWD_DEF = 2'b00;
  localparam logic [1:0] FWD_B   = 2'b01;
  localparam logic [1:0] FWD_C   = 2'b10;

  typedef struct packed {
    logic [RW-1:0] a3;
    logic [TW-1:0] tnew;
  } stage_t;

  typedef struct packed {
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    stage_t        dst;
  } e_stage_t;

  // $0 is hardwired to zero, so it can never be a producer.
  function automatic logic reg_hit(input logic [RW-1:0] a3, input logic [RW-1:0] r);
    return (r != '0) && (a3 == r);
  endfunction

  function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Youngest producer wins; a producer not yet ready leaves the regfile path selected.
  function automatic logic [1:0] d_sel(input stage_t e, input stage_t m, input logic [RW-1:0] r);
    if (reg_hit(e.a3, r)) return (e.tnew == '0) ? FWD_C : FWD_DEF;
    if (reg_hit(m.a3, r)) return (m.tnew == '0) ? FWD_B : FWD_DEF;
    return FWD_DEF;
  endfunction

  function automatic logic [1:0] e_sel(input stage_t m, input stage_t w, input logic [RW-1:0] r);
    if (reg_hit(m.a3, r) && (m.tnew == '0)) return FWD_B;
    if (reg_hit(w.a3, r)) return FWD_C;
    return FWD_DEF;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_md_busy.sv
// HI/LO unit occupancy counter: busy is combinational from md_start, then counts down.
// A start arriving while the counter is nonzero is ignored.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic md_start_i,
  input  logic md_is_div_i,
  output logic md_busy_o
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else if (md_start_i) begin
      cnt_d = md_is_div_i ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign md_busy_o = md_start_i | (cnt_q != '0);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller: zero-latency stall and mux selects from E/M/W records.
// Stall freezes D and bubbles E; HI/LO busy stall only with HAZARD_MULTDIV_STALL_EN.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          d_valid,
  input  logic [RW-1:0] d_rs,
  input  logic [RW-1:0] d_rt,
  input  logic          d_use_rs,
  input  logic          d_use_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [RW-1:0] d_a3,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_is_md,
  input  logic          md_start,
  input  logic          md_is_div,
  output logic          stall,
  output logic [1:0]    fwd_d_rs,
  output logic [1:0]    fwd_d_rt,
  output logic [1:0]    fwd_e_rs,
  output logic [1:0]    fwd_e_rt,
  output logic          md_busy
);

  e_stage_t e_q, e_d;
  stage_t   m_q, m_d;
  stage_t   w_q, w_d;

  logic haz_rs, haz_rt, md_stall;

`ifdef HAZARD_MULTDIV_STALL_EN
  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .md_start_i  (md_start),
    .md_is_div_i (md_is_div),
    .md_busy_o   (md_busy)
  );
  assign md_stall = d_is_md & md_busy;
`else
  logic unused_md;
  assign unused_md = ^{d_is_md, md_start, md_is_div, MULT_CYCLES[0], DIV_CYCLES[0]};
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif

  // W tnew is tracked for completeness; writeback forwarding ignores it.
  logic unused_w;
  assign unused_w = ^w_q.tnew;

  always_comb begin
    haz_rs = d_use_rs &&
             ((reg_hit(e_q.dst.a3, d_rs) && (e_q.dst.tnew > d_tuse_rs)) ||
              (reg_hit(m_q.a3, d_rs)     && (m_q.tnew > d_tuse_rs)));
    haz_rt = d_use_rt &&
             ((reg_hit(e_q.dst.a3, d_rt) && (e_q.dst.tnew > d_tuse_rt)) ||
              (reg_hit(m_q.a3, d_rt)     && (m_q.tnew > d_tuse_rt)));
    stall  = d_valid && (haz_rs || haz_rt || md_stall);
  end

  always_comb begin
    fwd_d_rs = d_sel(e_q.dst, m_q, d_rs);
    fwd_d_rt = d_sel(e_q.dst, m_q, d_rt);
    fwd_e_rs = e_sel(m_q, w_q, e_q.rs);
    fwd_e_rt = e_sel(m_q, w_q, e_q.rt);
  end

  always_comb begin
    e_d = '0;
    if (d_valid && !stall) begin
      e_d.rs       = d_rs;
      e_d.rt       = d_rt;
      e_d.dst.a3   = d_a3;
      e_d.dst.tnew = d_tnew;
    end
    m_d.a3   = e_q.dst.a3;
    m_d.tnew = tnew_dec(e_q.dst.tnew);
    w_d.a3   = m_q.a3;
    w_d.tnew = tnew_dec(m_q.tnew);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl; multdiv scenarios follow HAZARD_MULTDIV_STALL_EN.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       d_valid, d_use_rs, d_use_rt, d_is_md, md_start, md_is_div;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_a3(d_a3), .d_tnew(d_tnew),
    .d_is_md(d_is_md), .md_start(md_start), .md_is_div(md_is_div),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .md_busy(md_busy)
  );

  task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [1:0] trs,
                       input logic [1:0] trt, input logic [4:0] a3, input logic [1:0] tn);
    d_valid = v; d_rs = rs; d_rt = rt; d_use_rs = urs; d_use_rt = urt;
    d_tuse_rs = trs; d_tuse_rt = trt; d_a3 = a3; d_tnew = tn; d_is_md = 1'b0;
  endtask

  task automatic nop_d;
    set_d(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 2'd0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic flush;
    nop_d();
    md_start = 1'b0; md_is_div = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    nop_d();
    md_start = 1'b0; md_is_div = 1'b0;
    set_d(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 2'd0, 2'd0, 5'd7, 2'd0);
    #2;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", stall); end
    checks++;
    if (md_busy !== 1'b0) begin errors++; $display("FAIL rst_md_busy got=%b exp=0", md_busy); end
    checks++;
    if ({fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt} !== 8'h00) begin
      errors++; $display("FAIL rst_fwd got=%h exp=00", {fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt});
    end
    tick();
    tick();
    nop_d();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use;
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd8, 2'd2);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_lw_stall got=%b exp=0", stall); end
    tick();
    set_d(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 2'd1, 2'd1, 5'd9, 2'd1);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_c1 got=%b exp=1", stall); end
    tick();
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_c2 got=%b exp=0", stall); end
    checks++;
    if (fwd_d_rs !== 2'b00) begin errors++; $display("FAIL lu_fwd_d_rs got=%b exp=00", fwd_d_rs); end
    tick();
    nop_d();
    #1;
    checks++;
    if ({fwd_e_rs, fwd_e_rt} !== 4'b1000) begin
      errors++; $display("FAIL lu_fwd_e got=%b exp=1000", {fwd_e_rs, fwd_e_rt});
    end
    flush();
  endtask

  task automatic test_alu_fwd;
    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 2'd1, 2'd1, 5'd3, 2'd1);
    tick();
    set_d(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 2'd1, 2'd1, 5'd4, 2'd1);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got=%b exp=0", stall); end
    checks++;
    if ({fwd_d_rs, fwd_d_rt} !== 4'b0000) begin
      errors++; $display("FAIL alu_fwd_d got=%b exp=0000", {fwd_d_rs, fwd_d_rt});
    end
    tick();
    nop_d();
    #1;
    checks++;
    if ({fwd_e_rs, fwd_e_rt} !== 4'b0101) begin
      errors++; $display("FAIL alu_fwd_e got=%b exp=0101", {fwd_e_rs, fwd_e_rt});
    end
    flush();
  endtask

  task automatic test_branch_fwd;
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd5, 2'd0);
    tick();
    set_d(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 5'd0, 2'd0);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL br_stall got=%b exp=0", stall); end
    checks++;
    if ({fwd_d_rs, fwd_d_rt} !== 4'b1000) begin
      errors++; $display("FAIL br_fwd_d got=%b exp=1000", {fwd_d_rs, fwd_d_rt});
    end
    flush();
  endtask

  task automatic test_zero_reg;
    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 2'd1, 2'd1, 5'd0, 2'd1);
    tick();
    set_d(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 5'd6, 2'd1);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got=%b exp=0", stall); end
    checks++;
    if ({fwd_d_rs, fwd_d_rt} !== 4'b0000) begin
      errors++; $display("FAIL zero_fwd_d got=%b exp=0000", {fwd_d_rs, fwd_d_rt});
    end
    tick();
    nop_d();
    #1;
    checks++;
    if ({fwd_e_rs, fwd_e_rt} !== 4'b0000) begin
      errors++; $display("FAIL zero_fwd_e got=%b exp=0000", {fwd_e_rs, fwd_e_rt});
    end
    flush();
  endtask

  task automatic test_m_stall;
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd8, 2'd2);
    tick();
    nop_d();
    tick();
    set_d(1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd0, 2'd0);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL m_invalid_stall got=%b exp=0", stall); end
    d_valid = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL m_stall got=%b exp=1", stall); end
    tick();
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL m_stall_clear got=%b exp=0", stall); end
    checks++;
    if (fwd_d_rs !== 2'b00) begin errors++; $display("FAIL m_fwd_d_rs got=%b exp=00", fwd_d_rs); end
    flush();
  endtask

  task automatic test_priority;
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd7, 2'd0);
    tick();
    tick();
    set_d(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 2'd0, 2'd0, 5'd0, 2'd0);
    #1;
    checks++;
    if ({fwd_d_rs, fwd_d_rt} !== 4'b1010) begin
      errors++; $display("FAIL prio_fwd_d got=%b exp=1010", {fwd_d_rs, fwd_d_rt});
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL prio_stall got=%b exp=0", stall); end
    tick();
    set_d(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd0, 2'd0);
    #1;
    checks++;
    if (fwd_d_rs !== 2'b01) begin errors++; $display("FAIL prio_m_fwd_d got=%b exp=01", fwd_d_rs); end
    checks++;
    if ({fwd_e_rs, fwd_e_rt} !== 4'b0101) begin
      errors++; $display("FAIL prio_fwd_e got=%b exp=0101", {fwd_e_rs, fwd_e_rt});
    end
    flush();
  endtask

  task automatic test_async_reset;
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd5, 2'd0);
    tick();
    set_d(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd0, 2'd0);
    #1;
    checks++;
    if (fwd_d_rs !== 2'b10) begin errors++; $display("FAIL ar_pre got=%b exp=10", fwd_d_rs); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({stall, fwd_d_rs} !== 3'b000) begin
      errors++; $display("FAIL ar_clear got=%b exp=000", {stall, fwd_d_rs});
    end
    #2;
    reset_n = 1'b1;
    flush();
  endtask

`ifdef HAZARD_MULTDIV_STALL_EN
  task automatic test_multdiv;
    nop_d();
    md_start = 1'b1; md_is_div = 1'b1;
    #1;
    checks++;
    if (md_busy !== 1'b1) begin errors++; $display("FAIL md_busy_start got=%b exp=1", md_busy); end
    tick();
    md_start = 1'b0; md_is_div = 1'b0;
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 2'd0);
    d_is_md = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL md_stall_c%0d got=%b exp=1", i, stall); end
      tick();
    end
    #1;
    checks++;
    if ({stall, md_busy} !== 2'b00) begin
      errors++; $display("FAIL md_stall_end got=%b exp=00", {stall, md_busy});
    end
    flush();
    md_start = 1'b1; md_is_div = 1'b0;
    tick();
    md_start = 1'b0;
    tick();
    md_start = 1'b1; md_is_div = 1'b1;
    tick();
    md_start = 1'b0; md_is_div = 1'b0;
    tick();
    tick();
    checks++;
    if (md_busy !== 1'b1) begin errors++; $display("FAIL md_noreload_c5 got=%b exp=1", md_busy); end
    tick();
    checks++;
    if (md_busy !== 1'b0) begin errors++; $display("FAIL md_noreload_c6 got=%b exp=0", md_busy); end
    flush();
    md_start = 1'b1; md_is_div = 1'b1;
    tick();
    md_start = 1'b0; md_is_div = 1'b0;
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 2'd0);
    d_is_md = 1'b1;
    repeat (3) tick();
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL md_rst_pre got=%b exp=1", stall); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({stall, md_busy} !== 2'b00) begin
      errors++; $display("FAIL md_rst_clear got=%b exp=00", {stall, md_busy});
    end
    #1;
    reset_n = 1'b1;
    flush();
  endtask
`else
  task automatic test_multdiv;
    nop_d();
    md_start = 1'b1; md_is_div = 1'b1;
    #1;
    checks++;
    if (md_busy !== 1'b0) begin errors++; $display("FAIL md_off_busy got=%b exp=0", md_busy); end
    tick();
    md_start = 1'b0; md_is_div = 1'b0;
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 2'd0);
    d_is_md = 1'b1;
    #1;
    checks++;
    if ({stall, md_busy} !== 2'b00) begin
      errors++; $display("FAIL md_off_stall got=%b exp=00", {stall, md_busy});
    end
    flush();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_branch_fwd();
    test_zero_reg();
    test_m_stall();
    test_priority();
    test_async_reset();
    test_multdiv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
